// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_pkg
// Purpose  : Shared types and widths for the wait-state data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Responder transaction phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Interface: dmem_if
// Purpose  : Valid/ready request/response bundle between CPU and data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // CPU side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Word storage with synchronous byte-enabled write and
//            combinational read. Contents are not touched by reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [IDX_W-1:0]  idx,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [BE_W-1:0]   be,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with their enable set are updated
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read is asynchronous so the responder can sample it on its commit edge
  always_comb begin
    rdata = mem[idx];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Wait-state data-memory responder. Accepts one load/store at a
//            time, delays it WAIT_CYCLES cycles, performs the access and
//            holds the response until the CPU takes it.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input wire logic clk,
  input wire logic res,
  dmem_if.slave    bus
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              acc_err;
  logic              commit;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  // Address is rejected when misaligned or beyond the stored word range
  always_comb begin
    acc_err = (addr_q[1:0] != 2'b00) ||
              ({2'b00, addr_q[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
    commit  = (state == WAIT) && (cnt == '0);
    mem_we  = commit && wr_q && !acc_err;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (rd_word)
  );

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state    = state;
    bus.req_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = ~res;
        if (bus.req_valid) next_state = WAIT;
      end
      WAIT: begin
        if (cnt == '0) next_state = RESP;
      end
      RESP: begin
        if (bus.resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt     <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            err_q   <= acc_err;
            rdata_q <= (wr_q || acc_err) ? '0 : rd_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Response is presented for as long as the FSM sits in RESP
  always_comb begin
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (WAIT_CYCLES=2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH  = 256;
  localparam int WAIT_A = 2;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // Reference memories: only addresses the bench has written are known
  logic [31:0] mref_a [int];
  logic [31:0] mref_b [int];

  always #5 clk = ~clk;

  dmem_if bus ();
  dmem_if b0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut (
    .clk (clk), .res (res), .bus (bus.slave)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk (clk), .res (res), .bus (b0.slave)
  );

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  // Applies one transaction to reference memory A and returns the expected response
  task automatic model_a(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic er);
    er = model_err(a);
    rd = 32'h0;
    if (!er) begin
      if (wr) mref_a[a/4] = model_merge(mref_a.exists(a/4) ? mref_a[a/4] : 32'h0, wd, be);
      else    rd = mref_a[a/4];
    end
  endtask

  // Runs one full transaction on the WAIT_CYCLES=2 instance
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat, output bit was_ready);
    was_ready     = (bus.req_ready === 1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    @(posedge clk); #1;
    res = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || b0.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", bus.req_ready, b0.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rdy;
    model_a(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, erd, eer);
    txn(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, er, lat, rdy);
    checks++;
    if (!rdy || lat !== WAIT_A + 1 || rd !== erd || er !== eer) begin
      failures++;
      $display("FAIL store_0x20: got rdy=%b lat=%0d rdata=%h err=%b want 1 %0d %h %b",
               rdy, lat, rd, er, WAIT_A + 1, erd, eer);
    end
    model_a(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rdy);
    checks++;
    if (rd !== 32'hDEADBEEF || rd !== erd || er !== 1'b0 || lat !== WAIT_A + 1) begin
      failures++;
      $display("FAIL load_0x20: got rdata=%h err=%b lat=%0d want DEADBEEF 0 %0d", rd, er, lat,
               WAIT_A + 1);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rdy;
    model_a(1'b1, 32'h20, 32'h11223344, 4'b0101, erd, eer);
    txn(1'b1, 32'h20, 32'h11223344, 4'b0101, rd, er, lat, rdy);
    model_a(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rdy);
    checks++;
    if (rd !== 32'hDE22BE44 || rd !== erd) begin
      failures++;
      $display("FAIL be_0101: got %h want DE22BE44", rd);
    end
    model_a(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, erd, eer);
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, rdy);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL be_0000_resp: got err=%b rdata=%h want 0 00000000", er, rd);
    end
    model_a(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rdy);
    checks++;
    if (rd !== erd) begin
      failures++;
      $display("FAIL be_0000_unchanged: got %h want %h", rd, erd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rdy;
    model_a(1'b0, 32'h22, 32'h0, 4'h0, erd, eer);
    txn(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat, rdy);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || eer !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_load: got err=%b rdata=%h want 1 00000000", er, rd);
    end
    model_a(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, erd, eer);
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, rdy);
    model_a(1'b1, 32'h400, 32'h12345678, 4'hF, erd, eer);
    txn(1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat, rdy);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL range_store: got err=%b rdata=%h want 1 00000000", er, rd);
    end
    model_a(1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, rdy);
    checks++;
    if (rd !== 32'hCAFEF00D || rd !== erd) begin
      failures++;
      $display("FAIL range_store_word0: got %h want CAFEF00D", rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rdy; bit bad;
    model_a(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, erd, eer);
    txn(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, rd, er, lat, rdy);
    // Second store is dropped by reset; model is not updated
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h5A5A5A5A; bus.req_be = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    res = 1'b1;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait_during: got valid=%b ready=%b want 0 0", bus.resp_valid,
               bus.req_ready);
    end
    @(posedge clk); #1;
    res = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_wait_after: got valid=%b ready=%b want 0 1", bus.resp_valid,
               bus.req_ready);
    end
    model_a(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy);
    checks++;
    if (rd !== 32'hA5A5A5A5 || rd !== erd) begin
      failures++;
      $display("FAIL reset_mid_wait_mem: got %h want A5A5A5A5", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] erd, held; logic eer; int n; bit bad;
    model_a(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h20; bus.req_be = 4'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 64) begin
      @(posedge clk); #1; n++;
    end
    held = bus.resp_rdata;
    checks++;
    if (n !== WAIT_A + 1 || held !== erd) begin
      failures++;
      $display("FAIL bp_first_resp: got lat=%0d rdata=%h want %0d %h", n, held, WAIT_A + 1, erd);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = i[0];
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_wdata = $urandom;
      bus.req_be    = 4'hF;
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== held || bus.req_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: got valid=%b rdata=%h ready=%b want 1 %h 0", bus.resp_valid,
               bus.resp_rdata, bus.req_ready, held);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, erd; logic [3:0] be; logic wr, er, eer; int lat; bit rdy;
    int bad;
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 15)) * 4;
      case ($urandom_range(0, 7))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
        default: ;
      endcase
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      if (!wr && !model_err(a) && !mref_a.exists(a/4)) wr = 1'b1;
      if (wr && !model_err(a) && !mref_a.exists(a/4)) be = 4'hF;
      model_a(wr, a, wd, be, erd, eer);
      txn(wr, a, wd, be, rd, er, lat, rdy);
      checks++;
      if (!rdy || rd !== erd || er !== eer || lat !== WAIT_A + 1) begin
        failures++;
        bad++;
        $display("FAIL random_%0d: wr=%b addr=%h got rdata=%h err=%b lat=%0d want %h %b %0d",
                 t, wr, a, rd, er, lat, erd, eer, WAIT_A + 1);
      end
    end
  endtask

  // WAIT_CYCLES=0 instance: resp_ready tied high, requests always offered
  task automatic test_back_to_back();
    logic [31:0] q_addr [8];
    logic [31:0] q_wd [8];
    logic        q_wr [8];
    int          exp_edge [$];
    logic [31:0] exp_data [$];
    int          last_acc, next_i, seen;
    bit          acc;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      q_wr[i]   = (i < 4);
      q_addr[i] = 32'h40 + 32'(i % 4) * 4;
      q_wd[i]   = $urandom;
    end
    b0.resp_ready = 1'b1;
    b0.req_valid  = 1'b1;
    b0.req_write  = q_wr[0];
    b0.req_addr   = q_addr[0];
    b0.req_wdata  = q_wd[0];
    b0.req_be     = 4'hF;
    last_acc = -1; next_i = 0; seen = 0;
    for (int e = 0; e < 80 && seen < 8; e++) begin
      acc = (b0.req_valid === 1'b1 && b0.req_ready === 1'b1);
      if (b0.resp_valid === 1'b1) begin
        checks++;
        if (exp_edge.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_resp: got resp at edge %0d want none", e);
        end else begin
          if (exp_edge[0] !== e || b0.resp_rdata !== exp_data[0] || b0.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_resp: got edge=%0d rdata=%h err=%b want %0d %h 0", e,
                     b0.resp_rdata, b0.resp_err, exp_edge[0], exp_data[0]);
          end
          void'(exp_edge.pop_front());
          void'(exp_data.pop_front());
        end
        seen++;
      end
      if (acc) begin
        if (last_acc >= 0) begin
          checks++;
          if ((e + 1) - last_acc !== 3) begin
            failures++;
            $display("FAIL b2b_period: got %0d cycles want 3", (e + 1) - last_acc);
          end
        end
        last_acc = e + 1;
        d = 32'h0;
        if (q_wr[next_i]) mref_b[q_addr[next_i]/4] = q_wd[next_i];
        else              d = mref_b[q_addr[next_i]/4];
        exp_edge.push_back(e + 2);
        exp_data.push_back(d);
        next_i++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (next_i < 8) begin
          b0.req_write = q_wr[next_i];
          b0.req_addr  = q_addr[next_i];
          b0.req_wdata = q_wd[next_i];
        end else begin
          b0.req_valid = 1'b0;
        end
      end
    end
    checks++;
    if (seen !== 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d responses want 8", seen);
    end
    b0.req_valid  = 1'b0;
    b0.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = '0;      bus.resp_ready = 1'b0;
    b0.req_valid  = 1'b0; b0.req_write = 1'b0;  b0.req_addr = '0;
    b0.req_wdata  = '0;   b0.req_be = '0;       b0.resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_reset_mid_wait();
    test_backpressure();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Wait-state data-memory responder serving the processor's load/store port over a valid/ready request/response handshake. It is the memory-side end of the data interface: it accepts one CPU request at a time, holds it for a programmable number of wait cycles, commits the store or fetches the load word, and presents a response until the CPU takes it. It replaces the zero-latency data memory when the core is run against realistic memory timing.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; word index = req_addr[31:2]
- WAIT_CYCLES, 2, extra cycles between acceptance and access (0 allowed)

Ports:
- clk  in  1  clock, rising-edge
- res  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  store byte enables, bit i = byte lane i (bits [8i+7:8i])
- resp_valid  out  1  response present
- resp_ready  in  1  CPU accepts response
- resp_rdata  out  32  load data (0 for stores and errors)
- resp_err  out  1  address misaligned or out of range

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On edge with req_valid & req_ready: capture write, addr, wdata, be; load counter with WAIT_CYCLES; go WAIT.
- WAIT: req_ready = 0. If counter != 0, decrement. If counter == 0: perform access, load resp_rdata/resp_err, go RESP.
- Access: err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH_WORDS). Err: no write, rdata = 0. Load OK: rdata = word. Store OK: write bytes where be=1, others unchanged; rdata = 0. be = 4'b0000 store: no change, err = 0.
- RESP: resp_valid = 1; resp_rdata, resp_err stable until handshake. On edge with resp_ready: resp_valid → 0, go IDLE.
- Request inputs are ignored outside IDLE; only one transaction in flight.
- Memory array is not cleared by reset; contents undefined until written.

## Timing
- Reset (async): state IDLE, resp_valid 0, resp_rdata 0, resp_err 0. req_ready = (state == IDLE) & ~res, so 0 while res high.
- Acceptance at edge k → resp_valid high after edge k+WAIT_CYCLES+1.
- Store commits at edge k+WAIT_CYCLES+1; a load issued after handshake sees it.
- resp_ready high when resp_valid rises → handshake at next edge; req_ready high the cycle after. Minimum period WAIT_CYCLES+3 cycles per transaction.
- resp_ready may be held low indefinitely; response and state hold.
- Reset during WAIT before commit edge: transaction dropped, memory unchanged. Reset during RESP: response dropped, store already committed.
- Reset asserted simultaneous with acceptance edge: reset wins, nothing captured.

## Structure
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), ADDR_W = 32, DATA_W = 32, BE_W = 4.
- Sub-module dmem_array: DEPTH_WORDS×32 storage, synchronous byte-enabled write, combinational read; no reset. FSM, counter and response registers in dmem_responder.
- Counter width $clog2(WAIT_CYCLES+1), minimum 1.

## Test plan
- Reset mid-WAIT: res high during store to 0x10 before commit → after reset, load 0x10 returns previously written value, resp_valid 0 during/after reset until new request.
- Store/load, WAIT_CYCLES=2: store 0x0000_0020 ← 0xDEADBEEF be=1111 accepted at edge k → resp_valid after k+3, rdata 0, err 0; load 0x20 → 0xDEADBEEF.
- Byte enables: word 0x20 = 0xDEADBEEF, store 0x11223344 be=0101 → load returns 0xDE22BE44; be=0000 store leaves word unchanged, err 0.
- Errors: load 0x22 → err 1, rdata 0; store to 0x400 with DEPTH_WORDS=256 → err 1, word 0 unchanged.
- Backpressure: resp_ready low 10 cycles → resp_valid, rdata stable, req_ready 0, req_valid pulses ignored; raise resp_ready → handshake, req_ready 1 next cycle.
- WAIT_CYCLES=0 back-to-back with resp_ready tied 1: requests accepted every 3 cycles, each resp_valid 1 cycle after acceptance.
